// File: rtl/morse_sequencer.sv
// morse_sequencer: converts one Morse character per valid/ready handshake
// into timed key on/off intervals. A unit is one unit_tick pulse.
//
// state | meaning
// IDLE  | waiting for a character, sym_ready high
// MARK  | key on for the current element (1 unit dot, 3 units dash)
// SPACE | key off between elements of one character (1 unit)
// GAP   | trailing key-off gap (3 units, or 7 for a word end)
module morse_sequencer #(
    parameter int MAX_LEN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       unit_tick,
    input  logic       abort,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic [4:0] sym_bits,
    input  logic [2:0] sym_len,
    input  logic       sym_word_end,
    output logic       key_out,
    output logic       busy,
    output logic       char_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] bits_q, bits_d;
    logic [2:0] len_q, len_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] tick_q, tick_d;
    logic       word_end_q, word_end_d;
    logic       key_d, busy_d, done_d, ready_d;
    logic [2:0] target;
    logic [2:0] len_clamped;
    logic       last_tick;

    // Interval length of the current state and detection of its final tick.
    always_comb begin
        target = 3'd1;
        case (state_q)
            MARK:    target = bits_q[idx_q] ? 3'd3 : 3'd1;
            SPACE:   target = 3'd1;
            GAP:     target = word_end_q ? 3'd7 : 3'd3;
            default: target = 3'd1;
        endcase
        last_tick   = unit_tick && (tick_q == target - 3'd1);
        len_clamped = (sym_len > MAX_LEN_L) ? MAX_LEN_L : sym_len;
    end

    // Next-state, datapath and next registered-output computation.
    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        len_d      = len_q;
        idx_d      = idx_q;
        tick_d     = tick_q;
        word_end_d = word_end_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sym_valid && sym_ready) begin
                    bits_d     = {3'b000, sym_bits};
                    len_d      = len_clamped;
                    word_end_d = sym_word_end;
                    idx_d      = 3'd0;
                    tick_d     = 3'd0;
                    state_d    = (len_clamped != 3'd0) ? MARK : GAP;
                end
            end
            MARK: begin
                if (last_tick) begin
                    tick_d  = 3'd0;
                    state_d = (idx_q < len_q - 3'd1) ? SPACE : GAP;
                end else if (unit_tick) begin
                    tick_d = tick_q + 3'd1;
                end
            end
            SPACE: begin
                if (last_tick) begin
                    tick_d  = 3'd0;
                    idx_d   = idx_q + 3'd1;
                    state_d = MARK;
                end else if (unit_tick) begin
                    tick_d = tick_q + 3'd1;
                end
            end
            GAP: begin
                if (last_tick) begin
                    tick_d  = 3'd0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (unit_tick) begin
                    tick_d = tick_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any tick; in IDLE it is ignored so a request still lands.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            tick_d  = 3'd0;
            idx_d   = 3'd0;
            done_d  = 1'b0;
        end

        key_d   = (state_d == MARK);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bits_q     <= 8'd0;
            len_q      <= 3'd0;
            idx_q      <= 3'd0;
            tick_q     <= 3'd0;
            word_end_q <= 1'b0;
            key_out    <= 1'b0;
            busy       <= 1'b0;
            char_done  <= 1'b0;
            sym_ready  <= 1'b1;
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
            word_end_q <= word_end_d;
            key_out    <= key_d;
            busy       <= busy_d;
            char_done  <= done_d;
            sym_ready  <= ready_d;
        end
    end

endmodule
